ext_mem_loader: RTL
===================

Name: ext_mem_loader

Overview:
Boot-time program/data loader that sits directly upstream of the pipelined CPU top. It accepts a framed byte stream over a valid/ready interface and assembles little-endian 32-bit words. It drives the top's external memory-write port (Ext_MemWrite, Ext_WriteData, Ext_DataAdr) and holds the CPU in reset until the whole image has been written and its checksum verified.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written.
MAX_WORDS, 1024, largest accepted word count; a header above this value is an error.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  the byte on in_data is valid.
in_data  input  8  stream byte.
in_ready  output  1  loader accepts a byte this cycle; a transfer is in_valid & in_ready.
restart  input  1  one-cycle pulse; sampled only in DONE or ERROR.
Ext_MemWrite  output  1  one-cycle word write strobe to the CPU top.
Ext_WriteData  output  32  assembled word.
Ext_DataAdr  output  32  word byte address.
cpu_reset  output  1  active-high CPU reset; drives the CPU top's reset.
done  output  1  image loaded and verified.
error  output  1  length or checksum failure.
words_written  output  16  count of words written so far.

Behaviour:
- All outputs are registered.
- Reset values: in_ready=0, Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=BASE_ADDR, cpu_reset=1, done=0, error=0, words_written=0. State resets to LEN0.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N payload bytes with the least significant byte first, then one CHK byte equal to the XOR of all payload bytes.
- States: LEN0, LEN1, DATA, WRITE, CHK, DONE, ERROR.
- in_ready is 1 in LEN0, LEN1, DATA, CHK and ERROR. It is 0 in WRITE and DONE, and 0 on the first cycle after reset release; it rises the cycle after that.
- LEN0 -> LEN1 on a transfer; the byte is stored as the count's low byte.
- LEN1 on a transfer:
  - N > MAX_WORDS -> ERROR.
  - N == 0 -> CHK.
  - otherwise -> DATA. The byte counter and checksum clear; Ext_DataAdr = BASE_ADDR.
- DATA: each transfer shifts the byte into lane [8*k+7:8*k], k = 0..3, and XORs it into the checksum. On the 4th byte -> WRITE.
- WRITE lasts exactly one cycle:
  - Ext_MemWrite=1 with Ext_WriteData holding the full word.
  - At the end of the cycle words_written increments.
  - If words_written reaches N -> CHK. Otherwise -> DATA, and Ext_DataAdr advances by 4 (no wrap check is needed because N <= MAX_WORDS).
- Throughput: at most one word per 5 cycles.
- Ext_MemWrite is never asserted unless cpu_reset=1.
- Ext_DataAdr and Ext_WriteData hold their last values outside WRITE.
- CHK on a transfer:
  - byte == checksum -> DONE. The next cycle cpu_reset=0 and done=1.
  - mismatch -> ERROR with error=1.
- ERROR: cpu_reset stays 1. Incoming bytes are accepted and discarded (the stream is drained).
- restart in DONE or ERROR -> LEN0. The next cycle cpu_reset=1, done=0, error=0, words_written=0. restart in any other state is ignored.
- Asynchronous reset at any point, including mid-word or during WRITE, aborts immediately to the reset values. A partial word is never written.
- in_valid may drop between bytes for any number of cycles with no effect. A byte presented while in_ready=0 is not consumed and must be held by the source.

Decomposition:
- Shared package (loader_pkg):
  - state encoding (7 states, 3 bits);
  - frame constants: header length 2, trailer length 1, bytes per word 4;
  - checksum width 8.
- One sub-module, word_packer, is natural. It contains:
  - the 2-bit byte lane counter;
  - the 32-bit shift/assemble register;
  - the running XOR checksum, with clear and load controls.
- The FSM, address counter and word counter stay in ext_mem_loader.

Test Plan:
1. Normal two-word load. Stream 02 00 78 56 34 12 EF BE AD DE 2A.
   - Required: write 0x12345678 @ BASE_ADDR, then 0xDEADBEEF @ BASE_ADDR+4.
   - Each write strobe lasts one cycle.
   - words_written=2; done=1 and cpu_reset=0 the cycle after the 2A byte.
2. Bad checksum. Same stream but CHK=2B.
   - Required: error=1, cpu_reset stays 1, both words were still written.
   - Then pulse restart and resend the scenario-1 stream; required: done=1.
3. Empty image. Stream 00 00 00.
   - Required: no Ext_MemWrite pulse, done=1.
   - Same header with CHK=01 -> error=1.
4. Oversize header. Stream 01 04 (N=1025).
   - Required: error=1 right after LEN_HI; no write; later bytes accepted and discarded.
5. Backpressure and gaps. Randomize in_valid gaps; hold a byte valid through the WRITE cycle.
   - Required: in_ready=0 in WRITE; no byte is duplicated or lost; words match scenario 1.
6. Reset mid-word. Assert reset after 02 00 78 56.
   - Required: all outputs at reset values asynchronously, no write issued.
   - After release, the full scenario-1 stream loads correctly.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time image loader.
package loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        StLen0,
        StLen1,
        StData,
        StWrite,
        StChk,
        StDone,
        StError
    } state_e;

    // Frame layout: 2 header bytes, 4 bytes per word, 1 checksum byte
    localparam int unsigned HeaderLen    = 2;
    localparam int unsigned TrailerLen   = 1;
    localparam int unsigned BytesPerWord = 4;
    localparam int unsigned ChkWidth     = 8;

    // Total bytes in a well-formed frame carrying n words
    function automatic int unsigned frame_bytes(input int unsigned n);
        return HeaderLen + BytesPerWord * n + TrailerLen;
    endfunction

endpackage

// File: rtl/word_packer.sv
// Assembles little-endian 32-bit words from a byte stream and keeps a running XOR checksum.
module word_packer
    import loader_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [7:0]          byte_i,
    output logic [31:0]         word_o,
    output logic                last_o,
    output logic [ChkWidth-1:0] chk_o
);

    logic [1:0]          lane_q, lane_d;
    logic [31:0]         word_q, word_d;
    logic [ChkWidth-1:0] chk_q, chk_d;
    logic [31:0]         word_ins;

    // Next-state for lane counter, word register and checksum
    always_comb begin
        word_ins                 = word_q;
        word_ins[8*lane_q +: 8]  = byte_i;
        lane_d                   = lane_q;
        word_d                   = word_q;
        chk_d                    = chk_q;
        if (clear_i) begin
            lane_d = 2'd0;
            word_d = 32'd0;
            chk_d  = '0;
        end else if (load_i) begin
            lane_d = lane_q + 2'd1;
            word_d = word_ins;
            chk_d  = chk_q ^ byte_i;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= 2'd0;
            word_q <= 32'd0;
            chk_q  <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
            chk_q  <= chk_d;
        end
    end

    // word_o already contains the byte being loaded so the last lane completes the word
    assign word_o = word_ins;
    assign last_o = (lane_q == 2'(BytesPerWord - 1));
    assign chk_o  = chk_q;

endmodule

// File: rtl/ext_mem_loader.sv
// Framed byte-stream loader: writes a little-endian word image into CPU memory and holds the
// CPU in reset until the image checksum is verified.
module ext_mem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        restart,
    output logic        Ext_MemWrite,
    output logic [31:0] Ext_WriteData,
    output logic [31:0] Ext_DataAdr,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    state_e      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] n_q, n_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        memwrite_q, memwrite_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] words_q, words_d;

    logic                xfer;
    logic                pk_clear, pk_load, pk_last;
    logic [31:0]         pk_word;
    logic [ChkWidth-1:0] pk_chk;
    logic [15:0]         n_new;
    logic [15:0]         words_inc;

    word_packer u_word_packer (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clear_i (pk_clear),
        .load_i  (pk_load),
        .byte_i  (in_data),
        .word_o  (pk_word),
        .last_o  (pk_last),
        .chk_o   (pk_chk)
    );

    assign xfer      = in_valid & in_ready_q;
    assign n_new     = {in_data, len_lo_q};
    assign words_inc = words_q + 16'd1;

    // FSM next-state and registered-output next values
    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        n_d         = n_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        memwrite_d  = 1'b0;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;
        words_d     = words_q;
        pk_clear    = 1'b0;
        pk_load     = 1'b0;

        unique case (state_q)
            StLen0: begin
                if (xfer) begin
                    len_lo_d = in_data;
                    state_d  = StLen1;
                end
            end
            StLen1: begin
                if (xfer) begin
                    n_d      = n_new;
                    pk_clear = 1'b1;
                    if ({16'd0, n_new} > 32'(MAX_WORDS)) begin
                        state_d = StError;
                        error_d = 1'b1;
                    end else if (n_new == 16'd0) begin
                        state_d = StChk;
                    end else begin
                        state_d = StData;
                        addr_d  = BASE_ADDR;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    pk_load = 1'b1;
                    if (pk_last) begin
                        wdata_d    = pk_word;
                        memwrite_d = 1'b1;
                        state_d    = StWrite;
                    end
                end
            end
            StWrite: begin
                words_d = words_inc;
                if (words_inc == n_q) begin
                    state_d = StChk;
                end else begin
                    state_d = StData;
                    addr_d  = addr_q + 32'd4;
                end
            end
            StChk: begin
                if (xfer) begin
                    if (in_data == pk_chk) begin
                        state_d     = StDone;
                        cpu_reset_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        state_d = StError;
                        error_d = 1'b1;
                    end
                end
            end
            StDone: begin
                if (restart) begin
                    state_d     = StLen0;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                    words_d     = 16'd0;
                end
            end
            StError: begin
                // Bytes are accepted and dropped until restart
                if (restart) begin
                    state_d = StLen0;
                    error_d = 1'b0;
                    words_d = 16'd0;
                end
            end
            default: state_d = StLen0;
        endcase

        // Ready is a registered copy of "next state accepts bytes"
        in_ready_d = (state_d == StLen0) || (state_d == StLen1) || (state_d == StData) ||
                     (state_d == StChk)  || (state_d == StError);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StLen0;
            in_ready_q  <= 1'b0;
            len_lo_q    <= 8'd0;
            n_q         <= 16'd0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= 32'd0;
            memwrite_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            len_lo_q    <= len_lo_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            memwrite_q  <= memwrite_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
            words_q     <= words_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign Ext_MemWrite  = memwrite_q;
    assign Ext_WriteData = wdata_q;
    assign Ext_DataAdr   = addr_q;
    assign cpu_reset     = cpu_reset_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = words_q;

endmodule
